// File: rtl/armstrong_pkg.sv
// rtl/armstrong_pkg.sv - shared widths and FSM state type for the Armstrong number generator
package armstrong_pkg;

    localparam int NUM_W   = 10;  // binary candidate / out_num width
    localparam int DIGIT_W = 4;   // one BCD digit
    localparam int SUM_W   = 12;  // cube sum, max 3*729 = 2187
    localparam int CNT_W   = 4;   // found counter

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_EMIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/armstrong_cube_sum.sv
// rtl/armstrong_cube_sum.sv - combinational sum of cubes of three BCD digits
// Ports:
//   d2, d1, d0 : hundreds, tens and units digits (0..9)
//   sum        : d2^3 + d1^3 + d0^3, full 12-bit width
module armstrong_cube_sum
    import armstrong_pkg::*;
(
    input  logic [DIGIT_W-1:0] d2,
    input  logic [DIGIT_W-1:0] d1,
    input  logic [DIGIT_W-1:0] d0,
    output logic [SUM_W-1:0]   sum
);

    // Ten-entry cube table; non-BCD codes cannot occur and map to zero.
    function automatic logic [SUM_W-1:0] cube(input logic [DIGIT_W-1:0] d);
        case (d)
            4'd0:    cube = 12'd0;
            4'd1:    cube = 12'd1;
            4'd2:    cube = 12'd8;
            4'd3:    cube = 12'd27;
            4'd4:    cube = 12'd64;
            4'd5:    cube = 12'd125;
            4'd6:    cube = 12'd216;
            4'd7:    cube = 12'd343;
            4'd8:    cube = 12'd512;
            4'd9:    cube = 12'd729;
            default: cube = 12'd0;
        endcase
    endfunction

    assign sum = cube(d2) + cube(d1) + cube(d0);

endmodule

// File: rtl/armstrong.sv
// rtl/armstrong.sv - scans 0..LIMIT and offers every Armstrong number on a valid/ready port
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin a scan (only honoured while idle)
//   busy       : scan in progress (SCAN, EMIT or DONE)
//   out_num    : offered Armstrong number, held until accepted
//   out_valid  : out_num is on offer; taken when out_ready is also high
//   out_ready  : sink accepts out_num
//   found      : numbers accepted in the current scan
//   done       : single-cycle pulse at end of scan
module armstrong_generator
    import armstrong_pkg::*;
#(
    parameter int LIMIT = 999
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic [NUM_W-1:0] out_num,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] found,
    output logic             done
);

    localparam logic [NUM_W-1:0] LIMIT_N = NUM_W'(LIMIT);

    state_t             state;
    logic [NUM_W-1:0]   cand;
    logic [DIGIT_W-1:0] d2, d1, d0;
    logic [SUM_W-1:0]   sum;

    armstrong_cube_sum u_cube_sum (
        .d2  (d2),
        .d1  (d1),
        .d0  (d0),
        .sum (sum)
    );

    // Decimal digits track the binary candidate through cascaded BCD
    // counters so no divider is needed to split the candidate.
    logic               d0_wrap, d1_wrap;
    logic [DIGIT_W-1:0] d0_next, d1_next, d2_next;
    logic               match, at_limit;

    assign d0_wrap  = (d0 == 4'd9);
    assign d1_wrap  = (d1 == 4'd9);
    assign d0_next  = d0_wrap ? 4'd0 : d0 + 4'd1;
    assign d1_next  = d0_wrap ? (d1_wrap ? 4'd0 : d1 + 4'd1) : d1;
    assign d2_next  = (d0_wrap && d1_wrap) ? d2 + 4'd1 : d2;

    assign match    = ({{(SUM_W-NUM_W){1'b0}}, cand} == sum);
    assign at_limit = (cand == LIMIT_N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cand      <= '0;
            d2        <= '0;
            d1        <= '0;
            d0        <= '0;
            out_num   <= '0;
            out_valid <= 1'b0;
            found     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cand    <= '0;
                        d2      <= '0;
                        d1      <= '0;
                        d0      <= '0;
                        out_num <= '0;
                        found   <= '0;
                        busy    <= 1'b1;
                        state   <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (match) begin
                        out_num   <= cand;
                        out_valid <= 1'b1;
                        state     <= ST_EMIT;
                    end else if (at_limit) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        cand <= cand + 10'd1;
                        d2   <= d2_next;
                        d1   <= d1_next;
                        d0   <= d0_next;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        found     <= found + 4'd1;
                        if (at_limit) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            cand  <= cand + 10'd1;
                            d2    <= d2_next;
                            d1    <= d1_next;
                            d0    <= d0_next;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_armstrong_generator.sv
// tb/tb_armstrong_generator.sv - self-checking bench for armstrong_generator with a digit-arithmetic model
module tb_armstrong_generator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start     [3];
    logic       out_ready [3];
    logic       busy      [3];
    logic       out_valid [3];
    logic       done      [3];
    logic [9:0] out_num   [3];
    logic [3:0] found     [3];

    logic [3:0]  cs_d2, cs_d1, cs_d0;
    logic [11:0] cs_sum;

    int vectors = 0;
    int errors  = 0;

    int exp_q [3][$];
    int acc   [3];

    logic       prev_valid [3];
    logic       prev_ready [3];
    logic       prev_done  [3];
    logic [9:0] prev_num   [3];

    always #5 clk = ~clk;

    armstrong_generator #(.LIMIT(999)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .busy(busy[0]),
        .out_num(out_num[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .found(found[0]), .done(done[0])
    );
    armstrong_generator #(.LIMIT(200)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .busy(busy[1]),
        .out_num(out_num[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .found(found[1]), .done(done[1])
    );
    armstrong_generator #(.LIMIT(0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .busy(busy[2]),
        .out_num(out_num[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .found(found[2]), .done(done[2])
    );

    armstrong_cube_sum u_cs (
        .d2(cs_d2), .d1(cs_d1), .d0(cs_d0), .sum(cs_sum)
    );

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic int lim_of(input int i);
        return (i == 0) ? 999 : (i == 1) ? 200 : 0;
    endfunction

    function automatic int digit_cubes(input int n);
        int a, b, c;
        a = n / 100;
        b = (n / 10) % 10;
        c = n % 10;
        return a*a*a + b*b*b + c*c*c;
    endfunction

    task automatic build(input int i);
        exp_q[i].delete();
        for (int n = 0; n <= lim_of(i); n++)
            if (digit_cubes(n) == n) exp_q[i].push_back(n);
        acc[i] = 0;
    endtask

    // Scoreboard: every accepted offer must be the next model value, offers
    // must hold while stalled, found tracks acceptances, done is one cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                prev_valid[i] = 1'b0;
                prev_ready[i] = 1'b0;
                prev_done[i]  = 1'b0;
            end else begin
                if (prev_valid[i] && !prev_ready[i]) begin
                    check("hold_valid", out_valid[i], 1);
                    check("hold_num", out_num[i], prev_num[i]);
                end
                if (out_valid[i]) check("valid_implies_busy", busy[i], 1);
                if (prev_done[i]) check("done_one_cycle", done[i], 0);
                if (busy[i]) check("found_count", found[i], acc[i]);
                if (out_valid[i] && out_ready[i]) begin
                    if (exp_q[i].size() == 0) begin
                        vectors++;
                        errors++;
                        $display("FAIL unexpected_emit: inst %0d offered %0d, model has none left", i, out_num[i]);
                    end else begin
                        check("emit_value", out_num[i], exp_q[i].pop_front());
                        acc[i]++;
                    end
                end
                prev_valid[i] = out_valid[i];
                prev_ready[i] = out_ready[i];
                prev_done[i]  = done[i];
                prev_num[i]   = out_num[i];
            end
        end
    end

    // mode 0: ready always high, 1: ready low 5 cycles per offer, 2: random ready.
    task automatic run_scan(input int i, input int mode);
        int e, got, wcnt, n_exp, last;
        build(i);
        n_exp = exp_q[i].size();
        last  = exp_q[i][n_exp-1];
        out_ready[i] = (mode == 0);
        @(posedge clk); #1;
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        e = 0; got = 0; wcnt = 0;
        while (!got && e < 4000) begin
            if (e == 0) begin
                check("scan_entry_busy", busy[i], 1);
                check("scan_entry_valid", out_valid[i], 0);
            end
            if (e == 1) begin
                check("first_offer_valid", out_valid[i], 1);
                check("first_offer_num", out_num[i], 0);
            end
            if (done[i]) begin
                got = 1;
                start[i] = 1'b0;
            end else begin
                start[i] = ($urandom_range(0, 5) == 0);
                case (mode)
                    0: out_ready[i] = 1'b1;
                    1: begin
                        if (out_valid[i]) begin
                            out_ready[i] = (wcnt == 5);
                            wcnt = (wcnt == 5) ? 0 : wcnt + 1;
                        end else begin
                            out_ready[i] = 1'($urandom_range(0, 1));
                            wcnt = 0;
                        end
                    end
                    default: out_ready[i] = 1'($urandom_range(0, 1));
                endcase
                @(posedge clk); #1;
                e++;
            end
        end
        if (!got) begin
            vectors++;
            errors++;
            $display("FAIL scan_timeout: inst %0d no done after %0d cycles, required done", i, e);
            start[i] = 1'b0;
        end else begin
            if (mode == 0) begin
                check("done_latency", e, lim_of(i) + 1 + n_exp);
                if (i == 0) check("done_latency_999", e, 1006);
            end
            check("found_at_done", found[i], n_exp);
            check("queue_drained", exp_q[i].size(), 0);
            check("out_num_at_done", out_num[i], last);
            @(posedge clk); #1;
            check("done_cleared", done[i], 0);
            check("idle_busy", busy[i], 0);
            check("found_hold", found[i], n_exp);
            check("out_num_hold", out_num[i], last);
        end
    endtask

    task automatic reset_mid_emit();
        int k;
        build(0);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        k = 0;
        while (!(out_valid[0] && out_num[0] == 10'd153) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        out_ready[0] = 1'b0;
        check("reached_offer_153", out_num[0], 153);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", out_valid[0], 0);
        check("rst_found", found[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_done", done[0], 0);
        check("rst_out_num", out_num[0], 0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        out_ready[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle_busy", busy[0], 0);
        check("post_rst_idle_valid", out_valid[0], 0);
        run_scan(0, 2);
    endtask

    initial begin
        int tv [5];
        tv = '{999, 153, 407, 370, 0};
        for (int i = 0; i < 3; i++) begin
            start[i]      = 1'b0;
            out_ready[i]  = 1'b0;
            prev_valid[i] = 1'b0;
            prev_ready[i] = 1'b0;
            prev_done[i]  = 1'b0;
            prev_num[i]   = '0;
            acc[i]        = 0;
        end
        cs_d2 = '0; cs_d1 = '0; cs_d0 = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset_busy", busy[i], 0);
            check("reset_valid", out_valid[i], 0);
            check("reset_done", done[i], 0);
            check("reset_found", found[i], 0);
            check("reset_out_num", out_num[i], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            cs_d2 = 4'(tv[t] / 100);
            cs_d1 = 4'((tv[t] / 10) % 10);
            cs_d0 = 4'(tv[t] % 10);
            #1;
            check("cube_sum", cs_sum, digit_cubes(tv[t]));
            if (t == 0) check("cube_sum_999", cs_sum, 2187);
        end

        build(0);
        check("model_count_999", exp_q[0].size(), 6);
        check("model_999_third", exp_q[0][2], 153);
        check("model_999_fourth", exp_q[0][3], 370);
        check("model_999_last", exp_q[0][5], 407);
        build(1);
        check("model_count_200", exp_q[1].size(), 3);
        build(2);
        check("model_count_0", exp_q[2].size(), 1);
        check("model_0_value", exp_q[2][0], 0);

        run_scan(0, 0);
        run_scan(0, 1);
        run_scan(0, 2);
        run_scan(1, 0);
        run_scan(1, 1);
        run_scan(2, 0);
        run_scan(2, 2);
        reset_mid_emit();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/armstrong_generator.md
ARMSTRONG_GENERATOR -- requirements
Module: armstrong_generator

Interface
REQ-001 Parameter LIMIT, default 999, last candidate scanned; legal range 0..999.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  request a scan; sampled only in IDLE.
REQ-005 busy  output  1  high in every state except IDLE.
REQ-006 out_num  output  10  Armstrong number being offered, binary.
REQ-007 out_valid  output  1  out_num is valid; the downstream sink samples out_num when out_valid and out_ready are both high.
REQ-008 out_ready  input  1  downstream sink accepts out_num.
REQ-009 found  output  4  numbers accepted so far in the current scan, binary.
REQ-010 done  output  1  one-cycle pulse when a scan ends.

Function
REQ-011 The block SHALL scan candidates 0..LIMIT ascending, one candidate per SCAN cycle, and emit each candidate n where d2^3+d1^3+d0^3 == n (d2,d1,d0 = hundreds/tens/units decimal digits; leading zero digits contribute 0).
REQ-012 Digits SHALL be held in three cascaded BCD counters (units wraps 9->0 and carries to tens, tens carries to hundreds) advanced in lockstep with a 10-bit binary candidate counter; no divide or modulo hardware.
REQ-013 The cube sum SHALL be computed at 12 bits (maximum 3*729=2187) and compared to the zero-extended candidate with no truncation.
REQ-014 FSM states: IDLE, SCAN, EMIT, DONE; reset state IDLE.
REQ-015 IDLE: start=1 -> clear counters and found, go to SCAN; start=0 -> stay.
REQ-016 SCAN, match: load out_num with the candidate, go to EMIT. No match and candidate<LIMIT: increment, stay in SCAN. No match and candidate==LIMIT: go to DONE.
REQ-017 EMIT: out_valid=1 and out_num held stable until out_ready=1. On the accepting edge: increment found, then go to DONE if candidate==LIMIT, else increment candidate and go to SCAN.
REQ-018 DONE: assert done for exactly one cycle, go to IDLE; found and out_num hold their values until the next start.
REQ-019 out_valid SHALL be high only in EMIT, and SHALL stay high in EMIT until accepted; out_ready is ignored outside EMIT.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 Latency: start accepted on edge k -> candidate 0 evaluated in cycle k+1 -> out_valid=1 with out_num=0 from edge k+2.
REQ-022 With out_ready held high, each scanned candidate costs one cycle and each match one extra cycle; LIMIT=999 SHALL reach DONE 1006 cycles after entering SCAN.
REQ-023 LIMIT=0: emit 0, then DONE.

Reset
REQ-024 With rst_n low, all of the following SHALL hold immediately, regardless of state (including mid-EMIT): FSM=IDLE; counters=0; out_num=0; out_valid=0; found=0; done=0; busy=0.
REQ-025 An offer that has not yet been accepted when reset asserts SHALL be discarded; after reset releases, the block SHALL wait in IDLE for a new start.

Structure
REQ-026 A package armstrong_pkg SHALL hold the FSM state enum and the constants NUM_W=10, DIGIT_W=4, SUM_W=12, CNT_W=4.
REQ-027 Sub-module armstrong_cube_sum: combinational; three 4-bit digits in, 12-bit sum out; cubes by 10-entry lookup. It is instantiated once.

Verification
REQ-028 LIMIT=999, out_ready=1, pulse start -> out_num sequence 0,1,153,370,371,407; found=6; done pulses 1006 cycles after SCAN entry.
REQ-029 Backpressure: out_ready low for 5 cycles in each EMIT -> same sequence; out_num stable while out_valid=1 and out_ready=0; no loss, no duplicates.
REQ-030 LIMIT=200 -> emits 0,1,153, found=3; LIMIT=0 -> emits 0, found=1.
REQ-031 Assert rst_n low while 153 is offered (out_ready=0) -> out_valid=0, found=0, busy=0 immediately; a new start then emits 0 first.
REQ-032 Pulse start during SCAN and during EMIT -> no restart; sequence and found=6 unchanged.
REQ-033 Check the 12-bit sum: candidate 999 gives sum 2187, no match.
